// File: rtl/key_debounce_pulse_pkg.sv
// Shared lab I/O definitions: debounce FSM encoding, board clock, counter sizing.
package lab_io_pkg;

    localparam int CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        UP         = 2'd0,
        UP_TO_DOWN = 2'd1,
        DOWN       = 2'd2,
        DOWN_TO_UP = 2'd3
    } key_fsm_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Key bundle: raw active-low buttons in, debounced level and edge pulses out.
interface key_debounce_pulse_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] KEY_STATE;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;

    modport master (
        output KEY,
        input  KEY_STATE,
        input  KEY_PRESS,
        input  KEY_RELEASE
    );

    modport slave (
        input  KEY,
        output KEY_STATE,
        output KEY_PRESS,
        output KEY_RELEASE
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, optional auto-repeat.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import lab_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
`ifdef KEY_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
`endif
    parameter int CW              = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press,
    output logic lift
);

    localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0] sync;
    logic       down;
    key_fsm_e   st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic level_nxt, press_nxt, lift_nxt;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rcnt, rcnt_nxt;
    logic          rep, rep_nxt;
    logic [CW-1:0] rlim;
    assign rlim = rep ? RP_LAST : RD_LAST;
`endif

    // Reset to released so a held key after reset reads as a fresh press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], key};
    end

    assign down = ~sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= UP;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            lift  <= 1'b0;
        end else begin
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            lift  <= lift_nxt;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            rep  <= 1'b0;
        end else begin
            rcnt <= rcnt_nxt;
            rep  <= rep_nxt;
        end
    end
`endif

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        lift_nxt  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_nxt  = rcnt;
        rep_nxt   = rep;
`endif
        unique case (st)
            UP: begin
                if (down) begin
                    st_nxt  = UP_TO_DOWN;
                    cnt_nxt = '0;
                end
            end
            UP_TO_DOWN: begin
                if (!down) begin
                    st_nxt  = UP;
                    cnt_nxt = '0;
                end else if (cnt == D_LAST) begin
                    st_nxt    = DOWN;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_nxt  = '0;
                    rep_nxt   = 1'b0;
`endif
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DOWN: begin
                if (!down) begin
                    st_nxt  = DOWN_TO_UP;
                    cnt_nxt = '0;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rcnt == rlim) begin
                    press_nxt = 1'b1;
                    rcnt_nxt  = '0;
                    rep_nxt   = 1'b1;
                end else if (rcnt != CNT_MAX) begin
                    rcnt_nxt = rcnt + 1'b1;
                end
`endif
            end
            DOWN_TO_UP: begin
                // Repeat counter stays frozen here; a rejected glitch resumes it
                if (down) begin
                    st_nxt  = DOWN;
                    cnt_nxt = '0;
                end else if (cnt == D_LAST) begin
                    st_nxt    = UP;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    lift_nxt  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_nxt  = '0;
                    rep_nxt   = 1'b0;
`endif
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: st_nxt = UP;
        endcase
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// KEY conditioner: N_KEYS independent debounce channels on CLOCK_50.
// Define KEY_AUTOREPEAT_EN to add auto-repeat KEY_PRESS pulses while held.
module key_debounce_pulse
    import lab_io_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input logic           CLOCK_50,
    input logic           RESET,
    key_debounce_pulse_if.slave keys
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    logic [N_KEYS-1:0] level_v;
    logic [N_KEYS-1:0] press_v;
    logic [N_KEYS-1:0] lift_v;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef KEY_AUTOREPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .CW              (CW)
        ) u_ch (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key   (keys.KEY[i]),
            .level (level_v[i]),
            .press (press_v[i]),
            .lift  (lift_v[i])
        );
    end

    assign keys.KEY_STATE   = level_v;
    assign keys.KEY_PRESS   = press_v;
    assign keys.KEY_RELEASE = lift_v;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed scenarios plus random bouncing keys
// checked against a run-length reference model.
module tb_key_debounce_pulse;

    localparam int NK = 4;
    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 6;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    key_debounce_pulse_if #(.N_KEYS(NK)) kif ();

    key_debounce_pulse #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .keys     (kif.slave)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the 2-cycle-delayed key has disagreed
    // with it for D+1 consecutive edges; repeats count steady-held edges.
    logic [NK-1:0] h1, h2, m_lvl, m_prs, m_rel;
    int run [NK];
    int reps [NK];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= '1;
            h2 <= '1;
            m_lvl <= '0;
            m_prs <= '0;
            m_rel <= '0;
            for (int i = 0; i < NK; i++) begin
                run[i] <= 0;
                reps[i] <= 0;
            end
        end else begin
            h1 <= kif.KEY;
            h2 <= h1;
            for (int i = 0; i < NK; i++) begin
                m_prs[i] <= 1'b0;
                m_rel[i] <= 1'b0;
                if (~h2[i] != m_lvl[i]) begin
                    if (run[i] == D) begin
                        m_lvl[i] <= ~h2[i];
                        m_prs[i] <= ~h2[i];
                        m_rel[i] <= h2[i];
                        run[i] <= 0;
                        reps[i] <= 0;
                    end else begin
                        run[i] <= run[i] + 1;
                    end
                end else begin
                    run[i] <= 0;
                    if (AUTO && m_lvl[i] && run[i] == 0) begin
                        reps[i] <= reps[i] + 1;
                        if (reps[i] + 1 == RD ||
                            (reps[i] + 1 > RD && (reps[i] + 1 - RD) % RP == 0))
                            m_prs[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        kif.KEY = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (kif.KEY_STATE !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", kif.KEY_STATE);
        end
        checks++;
        if (kif.KEY_PRESS !== 4'h0) begin
            errors++;
            $display("FAIL reset_press got=%h exp=0", kif.KEY_PRESS);
        end
        checks++;
        if (kif.KEY_RELEASE !== 4'h0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", kif.KEY_RELEASE);
        end
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if ({kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE} !== 12'h0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got=%h exp=0", k,
                         {kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE});
            end
        end
    endtask

    task automatic test_press();
        logic [NK-1:0] ep;
        kif.KEY[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            ep = (k == 2 + D + 1) ? 4'b0001 : 4'b0000;
            checks++;
            if (kif.KEY_PRESS !== ep) begin
                errors++;
                $display("FAIL press_latency k=%0d got=%b exp=%b", k, kif.KEY_PRESS, ep);
            end
            checks++;
            if (kif.KEY_STATE !== ((k >= 2 + D + 1) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL press_state k=%0d got=%b", k, kif.KEY_STATE);
            end
        end
    endtask

    task automatic test_bounce();
        kif.KEY[1] = 1'b0;
        repeat (5) @(negedge clk);
        kif.KEY[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (kif.KEY_PRESS[1] !== 1'b0 || kif.KEY_STATE[1] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_reject k=%0d press=%b state=%b exp=0 0", k,
                         kif.KEY_PRESS[1], kif.KEY_STATE[1]);
            end
        end
    endtask

    task automatic test_release_bounce();
        for (int b = 0; b < 3; b++) begin
            kif.KEY[0] = 1'b1;
            repeat (4) begin
                @(negedge clk);
                checks++;
                if (kif.KEY_RELEASE !== 4'h0) begin
                    errors++;
                    $display("FAIL bounce_release got=%b exp=0000", kif.KEY_RELEASE);
                end
            end
            kif.KEY[0] = 1'b0;
            repeat (4) @(negedge clk);
        end
        kif.KEY[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (kif.KEY_RELEASE !== ((k == 2 + D + 1) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL release_latency k=%0d got=%b", k, kif.KEY_RELEASE);
            end
            checks++;
            if (kif.KEY_STATE[0] !== (k < 2 + D + 1)) begin
                errors++;
                $display("FAIL release_state k=%0d got=%b", k, kif.KEY_STATE[0]);
            end
        end
    endtask

    task automatic test_simultaneous_reset();
        kif.KEY[3:2] = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (kif.KEY_PRESS !== ((k == 2 + D + 1) ? 4'b1100 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_press k=%0d got=%b", k, kif.KEY_PRESS);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE} !== 12'h0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0",
                     {kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (kif.KEY_PRESS !== ((k == 2 + D + 1) ? 4'b1100 : 4'b0000)) begin
                errors++;
                $display("FAIL fresh_press k=%0d got=%b", k, kif.KEY_PRESS);
            end
            checks++;
            if (kif.KEY_RELEASE !== 4'b0000) begin
                errors++;
                $display("FAIL no_release k=%0d got=%b exp=0000", k, kif.KEY_RELEASE);
            end
        end
        kif.KEY[3:2] = 2'b11;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_autorepeat();
        logic ep;
        int off;
        kif.KEY[0] = 1'b0;
        for (int k = 1; k <= 2 + D + 1 + 60; k++) begin
            @(negedge clk);
            off = k - (2 + D + 1);
            ep = (off == 0) ||
                 (AUTO && off >= RD && (off - RD) % RP == 0);
            checks++;
            if (kif.KEY_PRESS[0] !== ep) begin
                errors++;
                $display("FAIL repeat_press off=%0d got=%b exp=%b", off, kif.KEY_PRESS[0], ep);
            end
        end
        kif.KEY[0] = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic test_random();
        int hold [NK];
        for (int i = 0; i < NK; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    kif.KEY[i] = ~kif.KEY[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ?
                              int'($urandom_range(1, 6)) : int'($urandom_range(9, 60));
                end
            end
            if (c == 1500) rst = 1'b1;
            if (c == 1502) rst = 1'b0;
            @(negedge clk);
            checks++;
            if ({kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE} !== {m_lvl, m_prs, m_rel}) begin
                errors++;
                $display("FAIL random_model c=%0d got s=%b p=%b r=%b exp s=%b p=%b r=%b", c,
                         kif.KEY_STATE, kif.KEY_PRESS, kif.KEY_RELEASE, m_lvl, m_prs, m_rel);
            end
            checks++;
            if ((kif.KEY_PRESS & kif.KEY_RELEASE) !== 4'b0000) begin
                errors++;
                $display("FAIL press_and_release c=%0d got=%b exp=0000", c,
                         kif.KEY_PRESS & kif.KEY_RELEASE);
            end
        end
    endtask

    initial begin
        kif.KEY = 4'hF;
        test_reset();
        test_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous_reset();
        test_autorepeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
